shift_sequencer: RTL and testbench
==================================

Name: shift_sequencer

Overview:
- Multi-cycle controller for the shift unit: the shift register, its 3:1 entry-select mux (IR[15:0] / B / A) and its shift-amount select.
- Accepts one shift request from the main control FSM.
- Drives entry select for a LOAD cycle, then one SHIFT cycle, then optional settle cycles, then a one-cycle `done` pulse.
- Removes per-op shift sequencing from the main FSM; the main FSM only issues `start` and waits for `done`.

Parameters:
- SETTLE_CYCLES, 0, idle cycles between SHIFT and DONE (0..15) for slow result capture paths.
- CNT_W, 4, width of the settle counter; must hold SETTLE_CYCLES.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request strobe; sampled only in IDLE.
- op  input  3  000 SLL, 001 SRL, 010 SRA, 011 SLLV, 100 SRAV, 101 LUI, 110/111 illegal.
- EntryCtrl  output  2  entry mux select: 00 IR[15:0], 01 B, 10 A.
- ShiftAmtCtrl  output  2  amount select: 00 IR shamt, 01 A[4:0], 10 constant 16.
- ShiftCtrl  output  3  shift register command: 000 nop, 001 load, 010 left n, 011 right logical n, 100 right arithmetic n.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the result is valid in the shift register.
- err  output  1  one-cycle pulse, coincident with `done`, for an illegal op.

Behaviour:
- Reset, asynchronous: state=IDLE, latched op=000, counter=0. All outputs are 0 while reset is asserted and in IDLE.
- Outputs are Moore: decoded from the registered state and the latched op only; no input-to-output combinational path.
- States and transitions:
  - IDLE: `start`=1 latches `op`. Legal op goes to LOAD; illegal op goes to DONE with err_flag set.
  - LOAD (1 cycle): ShiftCtrl=001. EntryCtrl per op: SLL/SRL/SRA/SLLV/SRAV drive 01 (B); LUI drives 00 (IR). Next state is SHIFT.
  - SHIFT (1 cycle): ShiftCtrl per op: SLL/SLLV/LUI drive 010, SRL drives 011, SRA/SRAV drive 100. ShiftAmtCtrl per op: SLL/SRL/SRA drive 00, SLLV/SRAV drive 01, LUI drives 10. Next state is WAIT if SETTLE_CYCLES>0, else DONE.
  - WAIT: ShiftCtrl=000. Counter runs 0..SETTLE_CYCLES-1; at terminal count go to DONE and clear the counter.
  - DONE (1 cycle): done=1; err=err_flag. Next state is IDLE; clear err_flag.
- Outside LOAD, EntryCtrl=00. Outside SHIFT, ShiftAmtCtrl=00. Outside LOAD and SHIFT, ShiftCtrl=000.
- Latency, legal op: start sampled at edge N; LOAD is cycle N+1; SHIFT is N+2; `done` is high in cycle N+3+SETTLE_CYCLES.
- Latency, illegal op: `done` and `err` are high in cycle N+1. The shift register receives no command (ShiftCtrl stays 000).
- `start` while busy is ignored (not queued). `op` changes while busy have no effect.
- `start` held high continuously: a new operation begins on the first IDLE cycle after DONE. Back-to-back throughput is one op per 4+SETTLE_CYCLES cycles.
- Amount 0 (e.g. shamt=0): the SHIFT cycle is still issued (shift by 0); timing is unchanged.
- Reset mid-operation: immediate return to IDLE with all outputs 0. No `done` is produced for the aborted op.

Decomposition:
- Shared package holds:
  - op codes (OP_SLL..OP_LUI);
  - EntryCtrl encodings (ENTRY_IMM=00, ENTRY_B=01, ENTRY_A=10);
  - ShiftAmtCtrl encodings (AMT_SHAMT, AMT_A, AMT_16);
  - ShiftCtrl command encodings (SH_NOP, SH_LOAD, SH_LEFT, SH_RLOG, SH_RARITH);
  - state encoding.
- The main control FSM imports the same op codes.
- No sub-module needed; the op-decode lookup is a function in the package (shift_decode).

Test Plan:
- Reset held, then released with start=0 → all outputs 0, busy=0 for 5 cycles.
- start=1, op=000 (SLL), SETTLE_CYCLES=0 → cycle+1: ShiftCtrl=001, EntryCtrl=01. Cycle+2: ShiftCtrl=010, ShiftAmtCtrl=00. Cycle+3: done=1, err=0. Cycle+4: busy=0.
- op=101 (LUI) → LOAD cycle has EntryCtrl=00. SHIFT cycle has ShiftAmtCtrl=10, ShiftCtrl=010. With A=x, IR[15:0]=0x1234, shifter output=0x12340000.
- op=100 (SRAV), SETTLE_CYCLES=2 → SHIFT cycle has ShiftCtrl=100, ShiftAmtCtrl=01. Two WAIT cycles with ShiftCtrl=000. `done` arrives 5 cycles after start.
- op=111 → next cycle done=1, err=1. ShiftCtrl=000 throughout.
- Mid-op events: start=1 during SHIFT → ignored, exactly one `done`. Reset asserted during LOAD → outputs 0 asynchronously, no `done` after release.

Source files
------------

// File: rtl/shift_sequencer_pkg.sv
// Shared encodings for the shift unit sequencer: op codes, mux selects, shift commands
// and the per-op decode lookup.
package shift_sequencer_pkg;

   localparam logic [2:0] OP_SLL  = 3'b000;
   localparam logic [2:0] OP_SRL  = 3'b001;
   localparam logic [2:0] OP_SRA  = 3'b010;
   localparam logic [2:0] OP_SLLV = 3'b011;
   localparam logic [2:0] OP_SRAV = 3'b100;
   localparam logic [2:0] OP_LUI  = 3'b101;

   localparam logic [1:0] ENTRY_IMM = 2'b00;
   localparam logic [1:0] ENTRY_B   = 2'b01;
   localparam logic [1:0] ENTRY_A   = 2'b10;

   localparam logic [1:0] AMT_SHAMT = 2'b00;
   localparam logic [1:0] AMT_A     = 2'b01;
   localparam logic [1:0] AMT_16    = 2'b10;

   localparam logic [2:0] SH_NOP    = 3'b000;
   localparam logic [2:0] SH_LOAD   = 3'b001;
   localparam logic [2:0] SH_LEFT   = 3'b010;
   localparam logic [2:0] SH_RLOG   = 3'b011;
   localparam logic [2:0] SH_RARITH = 3'b100;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StShift,
      StWait,
      StDone
   } state_e;

   typedef struct packed {
      logic       legal;
      logic [1:0] entry;
      logic [1:0] amt;
      logic [2:0] sh;
   } shift_dec_t;

   function automatic shift_dec_t shift_decode(input logic [2:0] op);
      shift_dec_t d;
      d = '{legal: 1'b0, entry: ENTRY_IMM, amt: AMT_SHAMT, sh: SH_NOP};
      unique case (op)
         OP_SLL:  d = '{legal: 1'b1, entry: ENTRY_B,   amt: AMT_SHAMT, sh: SH_LEFT};
         OP_SRL:  d = '{legal: 1'b1, entry: ENTRY_B,   amt: AMT_SHAMT, sh: SH_RLOG};
         OP_SRA:  d = '{legal: 1'b1, entry: ENTRY_B,   amt: AMT_SHAMT, sh: SH_RARITH};
         OP_SLLV: d = '{legal: 1'b1, entry: ENTRY_B,   amt: AMT_A,     sh: SH_LEFT};
         OP_SRAV: d = '{legal: 1'b1, entry: ENTRY_B,   amt: AMT_A,     sh: SH_RARITH};
         OP_LUI:  d = '{legal: 1'b1, entry: ENTRY_IMM, amt: AMT_16,    sh: SH_LEFT};
         default: d = '{legal: 1'b0, entry: ENTRY_IMM, amt: AMT_SHAMT, sh: SH_NOP};
      endcase
      return d;
   endfunction

endpackage

// File: rtl/shift_sequencer.sv
// Multi-cycle shift unit controller: LOAD, SHIFT, optional settle wait, then a done pulse.
// Outputs are Moore, decoded from the registered state and latched op.
module shift_sequencer
   import shift_sequencer_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 0,
   parameter int unsigned CNT_W         = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [2:0] op,
   output logic [1:0] EntryCtrl,
   output logic [1:0] ShiftAmtCtrl,
   output logic [2:0] ShiftCtrl,
   output logic       busy,
   output logic       done,
   output logic       err
);

   // Guarded so SETTLE_CYCLES=0 does not wrap; WAIT is unreachable in that case.
   localparam int unsigned     LastInt = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;
   localparam logic [CNT_W-1:0] CntLast = CNT_W'(LastInt);

   state_e           state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
   shift_dec_t       dec_cur, dec_in;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         op_q    <= OP_SLL;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      cnt_d        = cnt_q;
      err_d        = err_q;
      EntryCtrl    = ENTRY_IMM;
      ShiftAmtCtrl = AMT_SHAMT;
      ShiftCtrl    = SH_NOP;
      busy         = 1'b1;
      done         = 1'b0;
      err          = 1'b0;
      dec_cur      = shift_decode(op_q);
      dec_in       = shift_decode(op);

      unique case (state_q)
         StIdle: begin
            busy = 1'b0;
            if (start) begin
               op_d = op;
               if (dec_in.legal) begin
                  state_d = StLoad;
               end else begin
                  err_d   = 1'b1;
                  state_d = StDone;
               end
            end
         end
         StLoad: begin
            ShiftCtrl = SH_LOAD;
            EntryCtrl = dec_cur.entry;
            state_d   = StShift;
         end
         StShift: begin
            ShiftCtrl    = dec_cur.sh;
            ShiftAmtCtrl = dec_cur.amt;
            state_d      = (SETTLE_CYCLES > 0) ? StWait : StDone;
         end
         StWait: begin
            if (cnt_q == CntLast) begin
               cnt_d   = '0;
               state_d = StDone;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StDone: begin
            done    = 1'b1;
            err     = err_q;
            err_d   = 1'b0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: one instance with no settle cycles, one with two.
module tb_shift_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       start0, start2;
   logic [2:0] op0, op2;
   logic [1:0] ent0, amt0, ent2, amt2;
   logic [2:0] sh0, sh2;
   logic       busy0, done0, err0, busy2, done2, err2;
   int         total = 0;
   int         bad = 0;

   always #5 clk = ~clk;

   shift_sequencer #(.SETTLE_CYCLES(0), .CNT_W(4)) dut0 (
      .clk(clk), .reset(reset), .start(start0), .op(op0),
      .EntryCtrl(ent0), .ShiftAmtCtrl(amt0), .ShiftCtrl(sh0),
      .busy(busy0), .done(done0), .err(err0)
   );

   shift_sequencer #(.SETTLE_CYCLES(2), .CNT_W(4)) dut2 (
      .clk(clk), .reset(reset), .start(start2), .op(op2),
      .EntryCtrl(ent2), .ShiftAmtCtrl(amt2), .ShiftCtrl(sh2),
      .busy(busy2), .done(done2), .err(err2)
   );

   // Packed view: {busy, done, err, ShiftCtrl, ShiftAmtCtrl, EntryCtrl}
   function automatic logic [9:0] pk(input logic b, input logic d, input logic e,
                                     input logic [2:0] sh, input logic [1:0] amt,
                                     input logic [1:0] ent);
      return {b, d, e, sh, amt, ent};
   endfunction

   task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   function automatic logic [9:0] o0();
      return {busy0, done0, err0, sh0, amt0, ent0};
   endfunction

   function automatic logic [9:0] o2();
      return {busy2, done2, err2, sh2, amt2, ent2};
   endfunction

   localparam logic [9:0] IDLE = 10'b0;

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; start0 = 1'b0; start2 = 1'b0; op0 = 3'b000; op2 = 3'b000;
      repeat (2) @(negedge clk);
      check("reset_held0", o0(), IDLE);
      check("reset_held2", o2(), IDLE);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("idle0", o0(), IDLE);
         check("idle2", o2(), IDLE);
      end

      // SLL, no settle
      start0 = 1'b1; op0 = 3'b000;
      @(negedge clk); start0 = 1'b0;
      check("sll_load", o0(), pk(1, 0, 0, 3'b001, 2'b00, 2'b01));
      @(negedge clk);
      check("sll_shift", o0(), pk(1, 0, 0, 3'b010, 2'b00, 2'b00));
      @(negedge clk);
      check("sll_done", o0(), pk(1, 1, 0, 3'b000, 2'b00, 2'b00));
      @(negedge clk);
      check("sll_idle", o0(), IDLE);

      // LUI
      start0 = 1'b1; op0 = 3'b101;
      @(negedge clk); start0 = 1'b0;
      check("lui_load", o0(), pk(1, 0, 0, 3'b001, 2'b00, 2'b00));
      @(negedge clk);
      check("lui_shift", o0(), pk(1, 0, 0, 3'b010, 2'b10, 2'b00));
      @(negedge clk);
      check("lui_done", o0(), pk(1, 1, 0, 3'b000, 2'b00, 2'b00));
      @(negedge clk);
      check("lui_idle", o0(), IDLE);

      // SRAV with two settle cycles
      start2 = 1'b1; op2 = 3'b100;
      @(negedge clk); start2 = 1'b0;
      check("srav_load", o2(), pk(1, 0, 0, 3'b001, 2'b00, 2'b01));
      @(negedge clk);
      check("srav_shift", o2(), pk(1, 0, 0, 3'b100, 2'b01, 2'b00));
      @(negedge clk);
      check("srav_wait1", o2(), pk(1, 0, 0, 3'b000, 2'b00, 2'b00));
      @(negedge clk);
      check("srav_wait2", o2(), pk(1, 0, 0, 3'b000, 2'b00, 2'b00));
      @(negedge clk);
      check("srav_done", o2(), pk(1, 1, 0, 3'b000, 2'b00, 2'b00));
      @(negedge clk);
      check("srav_idle", o2(), IDLE);

      // Illegal op on both instances
      start0 = 1'b1; op0 = 3'b111; start2 = 1'b1; op2 = 3'b110;
      @(negedge clk); start0 = 1'b0; start2 = 1'b0;
      check("ill_done0", o0(), pk(1, 1, 1, 3'b000, 2'b00, 2'b00));
      check("ill_done2", o2(), pk(1, 1, 1, 3'b000, 2'b00, 2'b00));
      @(negedge clk);
      check("ill_idle0", o0(), IDLE);
      check("ill_idle2", o2(), IDLE);

      // SRL with start/op toggled during SHIFT: ignored, single done, err stays 0
      start0 = 1'b1; op0 = 3'b001;
      @(negedge clk); start0 = 1'b0;
      check("srl_load", o0(), pk(1, 0, 0, 3'b001, 2'b00, 2'b01));
      @(negedge clk); start0 = 1'b1; op0 = 3'b111;
      check("srl_shift", o0(), pk(1, 0, 0, 3'b011, 2'b00, 2'b00));
      @(negedge clk); start0 = 1'b0;
      check("srl_done", o0(), pk(1, 1, 0, 3'b000, 2'b00, 2'b00));
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("srl_no_extra", o0(), IDLE);
      end

      // start held: next op begins on the IDLE cycle after DONE (4-cycle throughput)
      start0 = 1'b1; op0 = 3'b010;
      @(negedge clk);
      check("held_load1", o0(), pk(1, 0, 0, 3'b001, 2'b00, 2'b01));
      @(negedge clk);
      check("held_shift1", o0(), pk(1, 0, 0, 3'b100, 2'b00, 2'b00));
      @(negedge clk);
      check("held_done1", o0(), pk(1, 1, 0, 3'b000, 2'b00, 2'b00));
      @(negedge clk);
      check("held_idle", o0(), IDLE);
      @(negedge clk); start0 = 1'b0;
      check("held_load2", o0(), pk(1, 0, 0, 3'b001, 2'b00, 2'b01));
      @(negedge clk);
      check("held_shift2", o0(), pk(1, 0, 0, 3'b100, 2'b00, 2'b00));
      @(negedge clk);
      check("held_done2", o0(), pk(1, 1, 0, 3'b000, 2'b00, 2'b00));
      @(negedge clk);
      check("held_end", o0(), IDLE);

      // Reset asserted during LOAD: outputs drop asynchronously, no done afterwards
      start2 = 1'b1; op2 = 3'b000;
      @(negedge clk); start2 = 1'b0;
      check("rst_load", o2(), pk(1, 0, 0, 3'b001, 2'b00, 2'b01));
      #2 reset = 1'b1;
      #1;
      check("rst_async2", o2(), IDLE);
      check("rst_async0", o0(), IDLE);
      @(negedge clk); reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("rst_no_done", o2(), IDLE);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
